// File: rtl/adder_pkg.sv
// Shared types for the pipelined adder: op encoding, per-stage control word, chunk sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package adder_pkg;

  // Operation select as presented on in_sub.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Control half of a stage register. Operands and partial sum are kept as
  // separate WIDTH-wide vectors because their width is a module parameter.
  typedef struct packed {
    logic vld;    // stage holds a live operation
    logic carry;  // carry out of the chunk this stage added
  } stage_ctl_t;

  // Bits added per stage. The caller must keep width a multiple of stages.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Purpose: W-bit combinational add with carry in and carry out.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing stage decides when the result is captured.
// Ports: a/b operands, cin carry in, sum W-bit result, cout carry out of the MSB.
module adder_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Purpose: WIDTH-bit ADD/SUB split into STAGES chunk adders, one chunk per pipeline stage.
// Latency: STAGES cycles from input transfer to out_valid; 1 op/cycle sustained.
// Backpressure: a stage advances when the next is empty or advancing; out_ready stalls the chain losslessly.
// Ports: clk/resetn (async active-low), in_valid/in_ready/in_a/in_b/in_cin/in_sub operand channel,
//        flush kills all in-flight ops, out_valid/out_ready/out_sum/out_cout/out_ovf result channel.
// Build option: define PIPE_ADDER_OVF_EN to compute signed overflow; otherwise out_ovf is 0.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4   // WIDTH must be a multiple of STAGES
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  // Stage registers: stage k holds the op after chunk k has been added.
  stage_ctl_t [STAGES-1:0]            ctl_q;
  logic       [STAGES-1:0][WIDTH-1:0] a_q, b_q, sum_q;

  // Inputs seen by each stage (stage 0 from the port, stage k from stage k-1).
  logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_sum, sum_d;
  logic [STAGES-1:0]            src_c, src_vld, load, rdy;
  logic [STAGES-1:0][CHUNK-1:0] sl_a, sl_b, sl_sum;
  logic [STAGES-1:0]            sl_cout;

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // SUB is a + ~b + 1, so in_cin is ignored and carry out means "no borrow".
  assign op      = op_e'(in_sub);
  assign b_eff   = (op == OP_SUB) ? ~in_b : in_b;
  assign cin_eff = (op == OP_SUB) ? 1'b1 : in_cin;

  // Ready ripples back from the output; a full stage can still accept if it is draining.
  always_comb begin : ready_chain
    logic adv;
    adv = out_ready;
    rdy = '0;
    for (int k = LAST; k >= 0; k--) begin
      rdy[k] = !ctl_q[k].vld || adv;
      adv    = rdy[k];
    end
  end

  // resetn gates in_ready directly so it reads 0 for the whole reset window.
  assign in_ready = resetn && !flush && rdy[0];

  always_comb begin : stage_src
    src_a[0]   = in_a;
    src_b[0]   = b_eff;
    src_sum[0] = '0;
    src_c[0]   = cin_eff;
    src_vld[0] = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_sum[k] = sum_q[k-1];
      src_c[k]   = ctl_q[k-1].carry;
      src_vld[k] = ctl_q[k-1].vld;
    end
  end

  always_comb begin : slice_operands
    for (int k = 0; k < STAGES; k++) begin
      sl_a[k] = src_a[k][k*CHUNK +: CHUNK];
      sl_b[k] = src_b[k][k*CHUNK +: CHUNK];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.W(CHUNK)) u_slice (
      .a    (sl_a[k]),
      .b    (sl_b[k]),
      .cin  (src_c[k]),
      .sum  (sl_sum[k]),
      .cout (sl_cout[k])
    );
  end

  // Only chunk k of the running sum changes in stage k; other chunks pass through.
  always_comb begin : stage_next
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]                     = src_sum[k];
      sum_d[k][k*CHUNK +: CHUNK]   = sl_sum[k];
      load[k]                      = src_vld[k] && rdy[k];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctl_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush) begin
          ctl_q[k].vld <= 1'b0;
        end else if (rdy[k]) begin
          ctl_q[k].vld <= load[k];
          if (load[k]) begin
            a_q[k]         <= src_a[k];
            b_q[k]         <= src_b[k];
            sum_q[k]       <= sum_d[k];
            ctl_q[k].carry <= sl_cout[k];
          end
        end
      end
    end
  end

  assign out_valid = ctl_q[LAST].vld;
  assign out_sum   = sum_q[LAST];
  assign out_cout  = ctl_q[LAST].carry;

`ifdef PIPE_ADDER_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  logic ovf_d, ovf_q;

  assign ovf_d = (src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ sl_sum[LAST][CHUNK-1])
               ^ sl_cout[LAST];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
    end else if (!flush && load[LAST]) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

endmodule
